// File: rtl/dm_arb_pkg.sv
// Shared encodings and default policy constants for the DM port arbiter.
package dm_arb_pkg;

  typedef enum logic {
    S_CORE  = 1'b0,
    S_FORCE = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  localparam int STARVE_LIMIT_DEF = 8;
  localparam int BURST_MAX_DEF    = 4;

endpackage

// File: rtl/dm_port_arbiter_sat_counter.sv
// Saturating up-counter with clear. clr and inc together load 1, which lets
// the caller restart a count on the same cycle that counts as the first event.
module sat_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count register: reset/clear first, then saturating increment.
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (clr)
      cnt <= inc ? W'(1) : '0;
    else if (inc && cnt < W'(MAX))
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the DM port between the core (priority) and a DMA requester.
// A starvation counter forces a bounded DMA burst that stalls the core.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DMA_SIZE     = 16,
  parameter int DMD_SIZE     = 16,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int BURST_MAX    = BURST_MAX_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                core_cslt,
  input  logic                core_wrb,
  input  logic [DMA_SIZE-1:0] core_add,
  input  logic [DMD_SIZE-1:0] core_wdt,
  output logic                core_stall,
  output logic                core_rvalid,
  input  logic                dma_req,
  input  logic                dma_wrb,
  input  logic [DMA_SIZE-1:0] dma_add,
  input  logic [DMD_SIZE-1:0] dma_wdt,
  output logic                dma_gnt,
  output logic                dma_rvalid,
  output logic                arb_dm_cslt,
  output logic                arb_dm_wrb,
  output logic [DMA_SIZE-1:0] arb_dm_add,
  output logic [DMD_SIZE-1:0] arb_dm_wdt,
  input  logic [DMD_SIZE-1:0] dm_arb_rdt
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int BW = $clog2(BURST_MAX + 1);

  arb_state_t    state, state_nxt;
  owner_t        owner, rd_owner;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt;
  logic          s_clr, s_inc, b_clr, b_inc;
  logic          mux_wrb;

  sat_counter #(.MAX(STARVE_LIMIT), .W(SW)) u_starve (
    .clk(clk), .reset(reset), .clr(s_clr), .inc(s_inc), .cnt(starve_cnt)
  );

  sat_counter #(.MAX(BURST_MAX), .W(BW)) u_burst (
    .clk(clk), .reset(reset), .clr(b_clr), .inc(b_inc), .cnt(burst_cnt)
  );

  // Ownership policy and counter control for this cycle.
  always_comb begin
    state_nxt = state;
    owner     = OWN_NONE;
    s_clr     = 1'b0;
    s_inc     = 1'b0;
    b_clr     = 1'b0;
    b_inc     = 1'b0;
    case (state)
      S_CORE: begin
        if (dma_req && starve_cnt == SW'(STARVE_LIMIT)) begin
          owner     = OWN_DMA;
          state_nxt = S_FORCE;
          b_inc     = 1'b1;  // burst_cnt is 0 in S_CORE, so this loads 1
          s_clr     = 1'b1;
        end else if (core_cslt) begin
          owner = OWN_CORE;
          if (dma_req) s_inc = 1'b1;
          else         s_clr = 1'b1;
        end else begin
          if (dma_req) owner = OWN_DMA;
          s_clr = 1'b1;
        end
      end
      S_FORCE: begin
        if (dma_req && burst_cnt < BW'(BURST_MAX)) begin
          owner = OWN_DMA;
          b_inc = 1'b1;
          s_clr = 1'b1;
        end else begin
          state_nxt = S_CORE;
          b_clr     = 1'b1;
          s_clr     = 1'b1;
          // A core win over a still-pending DMA here is the first denied
          // cycle of the next window, keeping the saturated cadence at
          // exactly STARVE_LIMIT core / BURST_MAX DMA cycles.
          if (core_cslt) begin
            owner = OWN_CORE;
            s_inc = dma_req;
          end else if (dma_req) begin
            owner = OWN_DMA;
          end
        end
      end
      default: state_nxt = S_CORE;
    endcase
  end

  assign mux_wrb = (owner == OWN_DMA) ? dma_wrb : core_wrb;

  // State register and read-return owner tracking (1-cycle DM read latency).
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_CORE;
      rd_owner <= OWN_NONE;
    end else begin
      state    <= state_nxt;
      rd_owner <= (owner != OWN_NONE && !mux_wrb) ? owner : OWN_NONE;
    end
  end

  // Memory-side mux and handshakes; everything is held low during reset.
  always_comb begin
    arb_dm_cslt = 1'b0;
    arb_dm_wrb  = 1'b0;
    arb_dm_add  = '0;
    arb_dm_wdt  = '0;
    dma_gnt     = 1'b0;
    core_stall  = 1'b0;
    core_rvalid = 1'b0;
    dma_rvalid  = 1'b0;
    if (!reset) begin
      arb_dm_cslt = (owner != OWN_NONE);
      arb_dm_wrb  = (owner != OWN_NONE) && mux_wrb;
      arb_dm_add  = (owner == OWN_DMA) ? dma_add : core_add;
      arb_dm_wdt  = (owner == OWN_DMA) ? dma_wdt : core_wdt;
      dma_gnt     = (owner == OWN_DMA);
      core_stall  = core_cslt && (owner == OWN_DMA);
      core_rvalid = (rd_owner == OWN_CORE);
      dma_rvalid  = (rd_owner == OWN_DMA);
    end
  end

endmodule
